// File: rtl/pulse_checker.sv
// rtl/pulse_checker.sv - measures and classifies pulses on an asynchronous input
// Reports one registered strobe per pulse plus the latched width/gap of the last classified pulse.
module pulse_checker #(
    parameter int MIN_WIDTH     = 1,
    parameter int MAX_WIDTH     = 1000,
    parameter int MIN_GAP       = 100,
    parameter int COUNTER_WIDTH = 32,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pulse_in,
    output logic                     valid,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     err_gap,
    output logic [COUNTER_WIDTH-1:0] width,
    output logic [COUNTER_WIDTH-1:0] gap,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   pulse_count
);

    typedef enum logic [1:0] {ARM, GAP, PULSE} state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0]   TALLY_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] MIN_W     = COUNTER_WIDTH'(MIN_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] MAX_W     = COUNTER_WIDTH'(MAX_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] MIN_G     = COUNTER_WIDTH'(MIN_GAP);

    state_t                   state_q, state_d;
    logic                     sync1_q, sync2_q;
    logic [COUNTER_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [COUNTER_WIDTH-1:0] width_cnt_q, width_cnt_d;
    logic [COUNTER_WIDTH-1:0] gap_lat_q, gap_lat_d;
    logic                     long_flag_q, long_flag_d;
    logic                     end_q, end_d;
    logic                     valid_q, valid_d;
    logic                     err_short_q, err_short_d;
    logic                     err_long_q, err_long_d;
    logic                     err_gap_q, err_gap_d;
    logic [COUNTER_WIDTH-1:0] width_q, width_d;
    logic [COUNTER_WIDTH-1:0] gap_q, gap_d;
    logic [COUNT_WIDTH-1:0]   pulse_count_q, pulse_count_d;
    logic                     s;

    assign s = sync2_q;

    // Synchroniser resets high so a line already high at reset release looks like a pulse in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ARM;
            gap_cnt_q     <= '0;
            width_cnt_q   <= '0;
            gap_lat_q     <= '0;
            long_flag_q   <= 1'b0;
            end_q         <= 1'b0;
            valid_q       <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_gap_q     <= 1'b0;
            width_q       <= '0;
            gap_q         <= '0;
            pulse_count_q <= '0;
        end else begin
            sync1_q       <= pulse_in;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            width_cnt_q   <= width_cnt_d;
            gap_lat_q     <= gap_lat_d;
            long_flag_q   <= long_flag_d;
            end_q         <= end_d;
            valid_q       <= valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_gap_q     <= err_gap_d;
            width_q       <= width_d;
            gap_q         <= gap_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (!s) state_d = GAP;
            GAP:     if (s)  state_d = PULSE;
            PULSE:   if (!s) state_d = GAP;
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        gap_cnt_d     = gap_cnt_q;
        width_cnt_d   = width_cnt_q;
        gap_lat_d     = gap_lat_q;
        long_flag_d   = long_flag_q;
        end_d         = 1'b0;
        valid_d       = 1'b0;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        err_gap_d     = 1'b0;
        width_d       = width_q;
        gap_d         = gap_q;
        pulse_count_d = pulse_count_q;

        case (state_q)
            ARM: begin
                if (!s) gap_cnt_d = CNT_MAX;
            end
            GAP: begin
                if (!s) begin
                    if (gap_cnt_q != CNT_MAX) gap_cnt_d = gap_cnt_q + 1'b1;
                end else begin
                    gap_lat_d   = gap_cnt_q;
                    width_cnt_d = COUNTER_WIDTH'(1);
                    long_flag_d = 1'b0;
                end
            end
            PULSE: begin
                if (s) begin
                    if (width_cnt_q != CNT_MAX) width_cnt_d = width_cnt_q + 1'b1;
                    if (width_cnt_q == MAX_W && !long_flag_q) begin
                        long_flag_d = 1'b1;
                        err_long_d  = 1'b1;
                    end
                end else begin
                    gap_cnt_d = COUNTER_WIDTH'(1);
                    end_d     = 1'b1;
                end
            end
            default: ;
        endcase

        // Classification runs one cycle after the fall, from measurements frozen in GAP.
        if (end_q && !long_flag_q) begin
            width_d = width_cnt_q;
            gap_d   = gap_lat_q;
            if (width_cnt_q < MIN_W) begin
                err_short_d = 1'b1;
            end else if (gap_lat_q < MIN_G) begin
                err_gap_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                if (pulse_count_q != TALLY_MAX) pulse_count_d = pulse_count_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy        = (state_q == PULSE);
        valid       = valid_q;
        err_short   = err_short_q;
        err_long    = err_long_q;
        err_gap     = err_gap_q;
        width       = width_q;
        gap         = gap_q;
        pulse_count = pulse_count_q;
    end

endmodule

// File: doc/pulse_checker.md
Name: pulse_checker

Overview:
- Receive-side companion to the one-shot pulse generator.
- Samples an asynchronous pulse train, synchronises it, and measures each pulse's high width and the preceding low gap in clock cycles.
- Classifies each pulse as valid, too short, too long, or violating the minimum dead time, and reports the result as single-cycle strobes with latched measurements.
- Sits at the input of debug/synthesis-rig logic that consumes one-shot trigger pulses from another clock domain or an external pin.

Parameters:
MIN_WIDTH, 1, minimum legal high width in cycles (inclusive)
MAX_WIDTH, 1000, maximum legal high width in cycles (inclusive); must be < 2^COUNTER_WIDTH-1
MIN_GAP, 100, minimum legal low time before a pulse, in cycles (inclusive); must be < 2^COUNTER_WIDTH-1
COUNTER_WIDTH, 32, width of the width/gap counters and outputs
COUNT_WIDTH, 16, width of the valid-pulse tally

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous, active-low reset
pulse_in  input  1  asynchronous pulse input
valid  output  1  1-cycle strobe: legal pulse completed
err_short  output  1  1-cycle strobe: pulse ended with width < MIN_WIDTH
err_long  output  1  1-cycle strobe: pulse exceeded MAX_WIDTH (issued while still high)
err_gap  output  1  1-cycle strobe: width legal but preceding gap < MIN_GAP
width  output  COUNTER_WIDTH  width of last completed, non-long pulse
gap  output  COUNTER_WIDTH  gap preceding that pulse
busy  output  1  high while in state PULSE
pulse_count  output  COUNT_WIDTH  number of valid strobes since reset, saturating at all-ones

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Two-flop synchroniser flops forced to 1.
  - Counters 0; state ARM.
  - Deasserting reset mid-pulse therefore never reports a partial pulse.
- Synchronised sample s = second synchroniser flop. All counting uses s.
- State ARM: stay while s=1. On first s=0 go to GAP with gap_cnt = all-ones, so the first pulse after reset always passes the gap check and reports gap = 2^COUNTER_WIDTH-1.
- State GAP:
  - Each cycle with s=0: gap_cnt increments, saturating at all-ones.
  - On s=1: go to PULSE, latch gap_cnt into gap_lat, width_cnt = 1, clear long_flag.
- State PULSE:
  - Each cycle with s=1: width_cnt increments, saturating.
  - When width_cnt == MAX_WIDTH and s is still 1: set long_flag and pulse err_long for exactly one cycle on the next clock. Stay in PULSE; no further err_long for this pulse.
  - On s=0: go to GAP, gap_cnt = 1 (the first low cycle counts), then classify. Classification priority:
    1. long_flag set: no strobe; width/gap outputs unchanged.
    2. width_cnt < MIN_WIDTH: err_short; width <= width_cnt, gap <= gap_lat.
    3. gap_lat < MIN_GAP: err_gap; width/gap updated.
    4. Otherwise: valid; width/gap updated; pulse_count increments, saturating.
- Strobes are registered and high exactly one cycle.
- At most one of valid/err_short/err_gap per pulse. err_long is exclusive with those three for the same pulse.
- Latency: pulse_in rising sampled at edge k → busy high after edge k+2. Falling sampled at edge k → strobe high after edge k+3, with width/gap updated in the same cycle as the strobe.
- Widths/gaps are in cycles of s; ±1-cycle jitter from synchronisation is acceptable and must be tolerated by the bench.
- A pulse shorter than one clock may be missed entirely; this is not an error.
- MIN_WIDTH = 1 means err_short can never fire.

Test Plan:
- Reset with pulse_in=0, then 5-cycle high pulse → valid after 3 edges from fall; width=5, gap=2^32-1, pulse_count=1, busy high 5 cycles.
- Two 5-cycle pulses separated by 150 low cycles → second: valid, width=5, gap=150, pulse_count=2. Repeat with 40-cycle gap → err_gap, width=5, gap=40, pulse_count unchanged.
- MAX_WIDTH=10, pulse held 20 cycles → err_long exactly once, ~11 cycles after s rises; no strobe on fall; width/gap unchanged; next legal pulse after 100+ gap → valid.
- MIN_WIDTH=3, 2-cycle pulse after a 200-cycle gap → err_short, width=2; MIN_WIDTH=3, 3-cycle pulse → valid.
- Assert rst_n low mid-pulse and release with pulse_in still high → no strobe on its fall; next pulse reports gap=all-ones and valid.
- 70000 valid pulses with COUNT_WIDTH=16 → pulse_count saturates at 65535; 300-cycle pulse with MAX_WIDTH=1000 → width=300.
